// File: rtl/fp_pkg.sv
// Shared floating-point definitions: divider FSM states, exception flag
// bit positions and constant encodings parameterised by exponent/fraction width.
package fp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } div_state_e;

  // Flag vector layout: {invalid, div_by_zero, overflow, underflow, inexact}
  localparam int FLAG_W         = 5;
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIV_ZERO  = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // Widest encoding the constant helpers can build; callers truncate.
  localparam int FP_MAX_W = 128;

  // Positive infinity: exponent all ones, fraction zero, sign zero.
  function automatic logic [FP_MAX_W-1:0] fp_inf_bits(input int exp_w, input int frac_w);
    logic [FP_MAX_W-1:0] ones;
    ones = (FP_MAX_W'(1'b1) << exp_w) - FP_MAX_W'(1'b1);
    return ones << frac_w;
  endfunction

  // Canonical quiet NaN: sign zero, exponent all ones, fraction MSB set.
  function automatic logic [FP_MAX_W-1:0] fp_qnan_bits(input int exp_w, input int frac_w);
    return fp_inf_bits(exp_w, frac_w) | (FP_MAX_W'(1'b1) << (frac_w - 1));
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even and exponent range check for a normalised mantissa.
// Produces the packed result (overflow to infinity, flush-to-zero on
// underflow) plus the overflow/underflow/inexact flags.
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                     sign_i,
  input  logic signed [EXP_W+1:0]  exp_i,
  input  logic [FRAC_W:0]          mant_i,
  input  logic                     guard_i,
  input  logic                     sticky_i,
  output logic [EXP_W+FRAC_W:0]    result_o,
  output logic [FLAG_W-1:0]        flags_o
);

  localparam int DATA_W = 1 + EXP_W + FRAC_W;
  localparam logic signed [EXP_W+1:0] EXP_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic [DATA_W-1:0]       INF_BITS = DATA_W'(fp_inf_bits(EXP_W, FRAC_W));

  logic                    round_up_s;
  logic [FRAC_W+1:0]       mant_sum_s;
  logic                    carry_s;
  logic [FRAC_W-1:0]       frac_s;
  logic signed [EXP_W+1:0] exp_rnd_s;
  logic                    exp_low_s;
  logic                    exp_high_s;

  // Ties go to the even mantissa; a carry out of the hidden bit renormalises.
  assign round_up_s = guard_i & (sticky_i | mant_i[0]);
  assign mant_sum_s = {1'b0, mant_i} + {{(FRAC_W+1){1'b0}}, round_up_s};
  assign carry_s    = mant_sum_s[FRAC_W+1];
  assign frac_s     = carry_s ? mant_sum_s[FRAC_W:1] : mant_sum_s[FRAC_W-1:0];
  assign exp_rnd_s  = exp_i + $signed({{(EXP_W+1){1'b0}}, carry_s});
  assign exp_low_s  = exp_rnd_s[EXP_W+1] | (exp_rnd_s == {(EXP_W+2){1'b0}});
  assign exp_high_s = ~exp_rnd_s[EXP_W+1] & (exp_rnd_s >= EXP_MAX);

  // Select overflow infinity, flushed zero, or the rounded normal result
  always_comb begin
    result_o = {DATA_W{1'b0}};
    flags_o  = {FLAG_W{1'b0}};
    if (exp_high_s) begin
      result_o                = {sign_i, INF_BITS[DATA_W-2:0]};
      flags_o[FLAG_OVERFLOW]  = 1'b1;
      flags_o[FLAG_INEXACT]   = 1'b1;
    end else if (exp_low_s) begin
      result_o                = {sign_i, {(DATA_W-1){1'b0}}};
      flags_o[FLAG_UNDERFLOW] = 1'b1;
      flags_o[FLAG_INEXACT]   = 1'b1;
    end else begin
      result_o                = {sign_i, exp_rnd_s[EXP_W-1:0], frac_s};
      flags_o[FLAG_INEXACT]   = guard_i | sticky_i;
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 divider: one quotient bit per cycle using a restoring
// divider over hidden-bit mantissas, then a single rounding cycle. Special
// operands (NaN, infinity, zero) bypass the iteration and finish at once.
// Subnormal inputs are treated as zero and tiny results are flushed to zero.
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] in1,
  input  logic [EXP_W+FRAC_W:0] in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] out,
  output logic [FLAG_W-1:0]     flags
);

  localparam int DATA_W = 1 + EXP_W + FRAC_W;
  localparam int ITER   = FRAC_W + 3;
  localparam int CNT_W  = $clog2(ITER);
  localparam int REM_W  = FRAC_W + 2;
  localparam logic signed [EXP_W+1:0] BIAS    = (EXP_W+2)'((1 << (EXP_W-1)) - 1);
  localparam logic signed [EXP_W+1:0] EXP_ONE = (EXP_W+2)'(1);
  localparam logic [EXP_W-1:0]        EXP_ONES = {EXP_W{1'b1}};
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(ITER - 1);
  localparam logic [DATA_W-1:0]       QNAN_BITS = DATA_W'(fp_qnan_bits(EXP_W, FRAC_W));
  localparam logic [DATA_W-1:0]       INF_BITS  = DATA_W'(fp_inf_bits(EXP_W, FRAC_W));

  div_state_e              state_q, state_d;
  logic [REM_W-1:0]        rem_q, rem_d;
  logic [FRAC_W:0]         mb_q, mb_d;
  logic [ITER-1:0]         quo_q, quo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [EXP_W+1:0] exp_q, exp_d;
  logic                    sign_q, sign_d;
  logic [DATA_W-1:0]       out_q, out_d;
  logic [FLAG_W-1:0]       flags_q, flags_d;

  // Operand decode
  logic [EXP_W-1:0]  a_exp_s, b_exp_s;
  logic [FRAC_W-1:0] a_frac_s, b_frac_s;
  logic a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic sign_s;
  logic signed [EXP_W+1:0] exp_init_s;

  assign a_exp_s    = in1[DATA_W-2:FRAC_W];
  assign b_exp_s    = in2[DATA_W-2:FRAC_W];
  assign a_frac_s   = in1[FRAC_W-1:0];
  assign b_frac_s   = in2[FRAC_W-1:0];
  assign a_zero_s   = (a_exp_s == {EXP_W{1'b0}});
  assign b_zero_s   = (b_exp_s == {EXP_W{1'b0}});
  assign a_nan_s    = (a_exp_s == EXP_ONES) && (a_frac_s != {FRAC_W{1'b0}});
  assign b_nan_s    = (b_exp_s == EXP_ONES) && (b_frac_s != {FRAC_W{1'b0}});
  assign a_inf_s    = (a_exp_s == EXP_ONES) && (a_frac_s == {FRAC_W{1'b0}});
  assign b_inf_s    = (b_exp_s == EXP_ONES) && (b_frac_s == {FRAC_W{1'b0}});
  assign sign_s     = in1[DATA_W-1] ^ in2[DATA_W-1];
  assign exp_init_s = $signed({2'b00, a_exp_s}) - $signed({2'b00, b_exp_s}) + BIAS;

  logic              special_s;
  logic [DATA_W-1:0] spec_out_s;
  logic [FLAG_W-1:0] spec_flags_s;

  // Classify the operand pair and build the early result for special cases
  always_comb begin
    special_s    = 1'b1;
    spec_out_s   = {DATA_W{1'b0}};
    spec_flags_s = {FLAG_W{1'b0}};
    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      spec_out_s                  = QNAN_BITS;
      spec_flags_s[FLAG_INVALID]  = 1'b1;
    end else if (a_inf_s) begin
      spec_out_s                  = {sign_s, INF_BITS[DATA_W-2:0]};
    end else if (b_zero_s) begin
      spec_out_s                  = {sign_s, INF_BITS[DATA_W-2:0]};
      spec_flags_s[FLAG_DIV_ZERO] = 1'b1;
    end else if (b_inf_s || a_zero_s) begin
      spec_out_s                  = {sign_s, {(DATA_W-1){1'b0}}};
    end else begin
      special_s                   = 1'b0;
    end
  end

  // The single subtractor shared by every iteration; the extra top bit is the borrow.
  logic [REM_W:0]   sub_s;
  logic             q_bit_s;
  logic [REM_W-1:0] rem_next_s;
  logic             rem_nz_s;
  logic             last_iter_s;

  assign sub_s       = {1'b0, rem_q} - {2'b00, mb_q};
  assign q_bit_s     = ~sub_s[REM_W];
  assign rem_next_s  = q_bit_s ? sub_s[REM_W-1:0] : rem_q;
  assign rem_nz_s    = (rem_q != {REM_W{1'b0}});
  assign last_iter_s = (cnt_q == CNT_LAST);

  logic [FRAC_W:0]         norm_mant_s;
  logic                    norm_guard_s;
  logic                    norm_sticky_s;
  logic signed [EXP_W+1:0] norm_exp_s;

  // Normalise: a quotient below one is shifted left once and the exponent drops by one
  always_comb begin
    norm_mant_s   = quo_q[ITER-1:2];
    norm_guard_s  = quo_q[1];
    norm_sticky_s = quo_q[0] | rem_nz_s;
    norm_exp_s    = exp_q;
    if (quo_q[ITER-1]) begin
      norm_mant_s   = quo_q[ITER-1:2];
      norm_guard_s  = quo_q[1];
      norm_sticky_s = quo_q[0] | rem_nz_s;
      norm_exp_s    = exp_q;
    end else begin
      norm_mant_s   = quo_q[ITER-2:1];
      norm_guard_s  = quo_q[0];
      norm_sticky_s = rem_nz_s;
      norm_exp_s    = exp_q - EXP_ONE;
    end
  end

  logic [DATA_W-1:0] rnd_result_s;
  logic [FLAG_W-1:0] rnd_flags_s;

  fp_round_rne #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_round (
    .sign_i   (sign_q),
    .exp_i    (norm_exp_s),
    .mant_i   (norm_mant_s),
    .guard_i  (norm_guard_s),
    .sticky_i (norm_sticky_s),
    .result_o (rnd_result_s),
    .flags_o  (rnd_flags_s)
  );

  // FSM state register; reset aborts any division in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = special_s ? ST_DONE : ST_DIVIDE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIVIDE: begin
        if (last_iter_s) begin
          state_d = ST_ROUND;
        end else begin
          state_d = ST_DIVIDE;
        end
      end
      ST_ROUND: state_d = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake signals decoded from the registered state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath next state: load operands, iterate, then capture the rounded result
  always_comb begin
    rem_d   = rem_q;
    mb_d    = mb_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    out_d   = out_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = sign_s;
          if (special_s) begin
            out_d   = spec_out_s;
            flags_d = spec_flags_s;
          end else begin
            rem_d = {1'b0, 1'b1, a_frac_s};
            mb_d  = {1'b1, b_frac_s};
            quo_d = {ITER{1'b0}};
            cnt_d = {CNT_W{1'b0}};
            exp_d = exp_init_s;
          end
        end else begin
          sign_d = sign_q;
        end
      end
      ST_DIVIDE: begin
        rem_d = rem_next_s << 1'b1;
        quo_d = {quo_q[ITER-2:0], q_bit_s};
        cnt_d = cnt_q + CNT_ONE;
      end
      ST_ROUND: begin
        out_d   = rnd_result_s;
        flags_d = rnd_flags_s;
      end
      ST_DONE: begin
        out_d   = out_q;
        flags_d = flags_q;
      end
      default: begin
        out_d   = out_q;
        flags_d = flags_q;
      end
    endcase
  end

  // Datapath registers; the result registers clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q   <= {REM_W{1'b0}};
      mb_q    <= {(FRAC_W+1){1'b0}};
      quo_q   <= {ITER{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      exp_q   <= {(EXP_W+2){1'b0}};
      sign_q  <= 1'b0;
      out_q   <= {DATA_W{1'b0}};
      flags_q <= {FLAG_W{1'b0}};
    end else begin
      rem_q   <= rem_d;
      mb_q    <= mb_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign out   = out_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed corner cases with literal
// expectations, randomized operands checked against an arithmetic model,
// result-hold and mid-division reset scenarios.
module tb_fp_div_seq;

  typedef struct packed {
    logic        spec;
    logic [4:0]  fl;
    logic [31:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [4:0]  flags;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_queue[$];

  always #5 clk = ~clk;

  fp_div_seq #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact integer division of the mantissas, then round-nearest-even.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    logic   s, g, st;
    int     ea, eb, e;
    longint ma, mb, num, q, rm, m;
    bit     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    a_nan  = (ea == 255) && (a[22:0] != 23'd0);
    b_nan  = (eb == 255) && (b[22:0] != 23'd0);
    a_inf  = (ea == 255) && (a[22:0] == 23'd0);
    b_inf  = (eb == 255) && (b[22:0] == 23'd0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    r.spec = 1'b1;
    r.fl   = 5'd0;
    r.res  = 32'd0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      r.fl = 5'b10000; r.res = 32'h7FC0_0000; return r;
    end
    if (a_inf) begin
      r.res = {s, 31'h7F80_0000}; return r;
    end
    if (b_zero) begin
      r.fl = 5'b01000; r.res = {s, 31'h7F80_0000}; return r;
    end
    if (b_inf || a_zero) begin
      r.res = {s, 31'd0}; return r;
    end
    r.spec = 1'b0;
    ma  = 64'd8388608 + longint'(a[22:0]);
    mb  = 64'd8388608 + longint'(b[22:0]);
    num = ma * 64'd33554432;
    q   = num / mb;
    rm  = num % mb;
    e   = ea - eb + 127;
    if (q >= 64'd33554432) begin
      m = q / 4; g = q[1]; st = q[0] || (rm != 0);
    end else begin
      e = e - 1; m = q / 2; g = q[0]; st = (rm != 0);
    end
    if (g && (st || m[0])) m = m + 1;
    if (m == 64'd16777216) begin
      m = m / 2; e = e + 1;
    end
    if (e >= 255) begin
      r.fl = 5'b00101; r.res = {s, 31'h7F80_0000};
    end else if (e <= 0) begin
      r.fl = 5'b00011; r.res = {s, 31'd0};
    end else begin
      r.fl = {4'd0, g | st}; r.res = {s, e[7:0], m[22:0]};
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int          sel;
    v   = $urandom;
    sel = $urandom_range(0, 15);
    case (sel)
      0:       v[30:23] = 8'd0;
      1:       begin v[30:23] = 8'd255; v[22:0] = 23'd0; end
      2:       v[30:23] = 8'd255;
      3:       v[30:23] = 8'($urandom_range(1, 254));
      4:       v[30:23] = 8'($urandom_range(230, 254));
      5:       v[30:23] = 8'($urandom_range(1, 24));
      default: v[30:23] = 8'($urandom_range(107, 147));
    endcase
    return v;
  endfunction

  // Compare process: every cycle out of reset, check handshake state and any presented result
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("in_ready", 64'(in_ready), 64'(exp_queue.size() == 0));
      if (out_valid === 1'b1) begin
        if (exp_queue.size() == 0) begin
          check("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          check("out", 64'(out), 64'(exp_queue[0].res));
          check("flags", 64'(flags), 64'(exp_queue[0].fl));
          if (out_ready === 1'b1) void'(exp_queue.pop_front());
        end
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                        output logic [31:0] o, output logic [4:0] f);
    int   lat;
    int   wt;
    exp_t m;
    wt = 0;
    while (in_ready !== 1'b1 && wt < 100) begin
      @(posedge clk); #2; wt++;
    end
    check("in_ready_before_op", 64'(in_ready), 64'd1);
    m = model(a, b);
    in1 = a; in2 = b; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    exp_queue.push_back(m);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #2; lat++;
    end
    check("latency", 64'(lat), m.spec ? 64'd1 : 64'd28);
    o = out;
    f = flags;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      check("hold_out", 64'(out), 64'(o));
      check("hold_flags", 64'(flags), 64'(f));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
    end
    rst = 1'b0;
    exp_queue.delete();
  endtask

  logic [31:0] d_a [9] = '{32'h40C0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000,
                            32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 32'h4000_0000,
                            32'hC0C0_0000};
  logic [31:0] d_b [9] = '{32'h4000_0000, 32'h4040_0000, 32'h8000_0000, 32'h0000_0000,
                            32'h3E80_0000, 32'h4000_0000, 32'h4000_0000, 32'hFF80_0000,
                            32'h4000_0000};
  logic [31:0] d_r [9] = '{32'h4040_0000, 32'h3EAA_AAAB, 32'hFF80_0000, 32'h7FC0_0000,
                            32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h8000_0000,
                            32'hC040_0000};
  logic [4:0]  d_f [9] = '{5'b00000, 5'b00001, 5'b01000, 5'b10000,
                            5'b00101, 5'b00011, 5'b00000, 5'b00000,
                            5'b00000};

  initial begin
    logic [31:0] o;
    logic [4:0]  f;
    exp_t        m;
    bit          saw;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in1 = 32'd0; in2 = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    check("reset_out", 64'(out), 64'd0);
    check("reset_flags", 64'(flags), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed cases: pin the model and the DUT to hand-computed values
    for (int i = 0; i < 9; i++) begin
      m = model(d_a[i], d_b[i]);
      check("model_res", 64'(m.res), 64'(d_r[i]));
      check("model_flags", 64'(m.fl), 64'(d_f[i]));
      run_op(d_a[i], d_b[i], (i == 0) ? 10 : 0, o, f);
      check("directed_res", 64'(o), 64'(d_r[i]));
      check("directed_flags", 64'(f), 64'(d_f[i]));
    end

    // Randomized operands against the model
    for (int i = 0; i < 200; i++) begin
      run_op(rand_fp(), rand_fp(), $urandom_range(0, 3), o, f);
    end

    // Reset in the middle of a division: no result, ready next cycle
    in1 = 32'h40C0_0000; in2 = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    exp_queue.push_back(model(in1, in2));
    repeat (10) begin
      @(posedge clk); #2;
    end
    check("mid_div_busy", 64'(in_ready), 64'd0);
    pulse_reset(1);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out", 64'(out), 64'd0);
    check("abort_flags", 64'(flags), 64'd0);
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #2;
      if (out_valid === 1'b1) saw = 1'b1;
    end
    check("abort_no_result", 64'(saw), 64'd0);
    run_op(32'h3F80_0000, 32'h4040_0000, 1, o, f);
    check("recover_res", 64'(o), 64'h3EAA_AAAB);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter FRAC_W, default 23, stored fraction width; DATA_WIDTH = 1+EXP_W+FRAC_W (32 at default).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operands present.
REQ-006 SHALL have port in_ready, output, 1, block can accept operands.
REQ-007 SHALL have ports in1 and in2, input, DATA_WIDTH, IEEE-754 dividend and divisor.
REQ-008 SHALL have port out_valid, input-side handshake partner out_ready (input, 1), and out (output, DATA_WIDTH) quotient.
REQ-009 SHALL have port flags, output, 5, {invalid, div_by_zero, overflow, underflow, inexact}, valid with out.

Function
REQ-010 SHALL be a one-bit-per-cycle restoring divider over hidden-bit mantissas; ITER = FRAC_W+3 iterations.
REQ-011 SHALL use FSM states IDLE, DIVIDE, ROUND, DONE.
REQ-012 SHALL assert in_ready only in IDLE; acceptance is in_valid && in_ready at a rising edge; operands are registered then.
REQ-013 SHALL, for normal operands, go IDLE->DIVIDE (ITER cycles)->ROUND (1 cycle)->DONE; out_valid high in DONE only; 28 cycles accept-edge to out_valid at default widths.
REQ-014 SHALL, for special operands, go IDLE->DONE directly; out_valid 1 cycle after acceptance.
REQ-015 SHALL hold out and flags stable in DONE until out_valid && out_ready, then return to IDLE; no new acceptance in that same cycle.
REQ-016 SHALL compute sign = in1 sign XOR in2 sign for every result, including zero, infinity and overflow results.
REQ-017 SHALL compute the biased exponent as ea - eb + BIAS in EXP_W+2-bit signed arithmetic, minus 1 when the quotient MSB is 0, followed by a 1-bit left normalise.
REQ-018 SHALL round to nearest, ties to even, using a guard bit and a sticky bit (OR of the remaining quotient bits and remainder != 0); a mantissa carry-out increments the exponent.
REQ-019 SHALL treat exponent-0 inputs as signed zero (DAZ) and flush underflowing results to signed zero (FTZ), setting underflow and inexact.
REQ-020 SHALL return signed infinity on exponent >= 2^EXP_W-1 after rounding, setting overflow and inexact.
REQ-021 SHALL handle special cases: NaN operand, 0/0 or inf/inf -> canonical quiet NaN (exponent all-ones, fraction MSB set, sign 0) with invalid; finite/0 -> signed inf with div_by_zero; inf/finite -> signed inf; finite/inf -> signed zero; 0/nonzero -> signed zero; no flags except as stated.
REQ-022 SHALL set inexact whenever guard or sticky is nonzero.

Reset
REQ-023 SHALL, when rst is high at a clock edge, enter IDLE and clear out, flags and out_valid to 0, with in_ready = 1 the following cycle.
REQ-024 SHALL abort any in-flight division on reset without producing a result; reset has priority over handshakes.

Structure
REQ-025 SHALL place the FSM state enum, flag bit indices, and canonical-NaN / infinity constant functions of EXP_W/FRAC_W in shared package fp_pkg.
REQ-026 SHALL implement rounding and exponent range checks in a single combinational sub-module fp_round_rne, reusable by the multiplier and adder.
REQ-027 SHALL instantiate one FRAC_W+2-bit subtractor reused per iteration, not an unrolled array.

Verification
REQ-028 SHALL cover 0x40C00000 / 0x40000000 -> out 0x40400000, flags 0, out_valid 28 cycles after acceptance.
REQ-029 SHALL cover 0x3F800000 / 0x40400000 -> 0x3EAAAAAB, flags inexact only.
REQ-030 SHALL cover 0x3F800000 / 0x80000000 -> 0xFF800000 with div_by_zero after 1 cycle, and 0x00000000 / 0x00000000 -> 0x7FC00000 with invalid.
REQ-031 SHALL cover 0x7F000000 / 0x3E800000 -> 0x7F800000 with overflow and inexact, and 0x00800000 / 0x40000000 -> 0x00000000 with underflow and inexact.
REQ-032 SHALL cover out_ready held low 10 cycles in DONE -> out and flags unchanged and in_ready low throughout; rst pulsed mid-DIVIDE -> out_valid never rises, in_ready = 1 next cycle.
